// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- instruction fetch unit
//
// Producer side of the decode interface. Holds the fetch PC and issues one
// word read at a time to instruction memory over a valid/ready request
// channel. Each response is captured into an output register. That register
// presents a single {pc, inst} pair to decode under a valid/ready handshake.
// PC redirects (jal/jalr/branch resolution) re-steer the fetch stream and
// flush or kill whatever fetch is in flight.
//
// Ports
//   clk               in   single clock, rising edge
//   rst               in   asynchronous, active-low reset
//   o_imem_req_valid  out  fetch request valid (state == REQ)
//   i_imem_req_ready  in   imem accepts the request this cycle
//   o_imem_addr       out  word-aligned fetch address (= fetch PC)
//   i_imem_rsp_valid  in   one-cycle response strobe
//   i_imem_rsp_data   in   fetched instruction word
//   o_ifu_valid       out  {pc, inst} valid toward decode
//   i_ifu_ready       in   decode consumes the pair this cycle
//   o_ifu_pc          out  PC of the presented instruction
//   o_ifu_inst        out  presented instruction (NOP_INST when none held)
//   i_redirect_valid  in   one-cycle redirect pulse
//   i_redirect_pc     in   redirect target, bits [1:0] ignored
//   o_ifu_fetch_cnt   out  instructions delivered to decode (wraps at 2^32)
// ---------------------------------------------------------------------------
module ifu #(
   parameter int                   CPU_WIDTH = 32,
   parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(32'h8000_0000),
   parameter logic [31:0]          NOP_INST  = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 o_imem_req_valid,
   input  logic                 i_imem_req_ready,
   output logic [CPU_WIDTH-1:0] o_imem_addr,
   input  logic                 i_imem_rsp_valid,
   input  logic [31:0]          i_imem_rsp_data,
   output logic                 o_ifu_valid,
   input  logic                 i_ifu_ready,
   output logic [CPU_WIDTH-1:0] o_ifu_pc,
   output logic [31:0]          o_ifu_inst,
   input  logic                 i_redirect_valid,
   input  logic [CPU_WIDTH-1:0] i_redirect_pc,
   output logic [31:0]          o_ifu_fetch_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   state_t               state_q,     state_d;
   logic [CPU_WIDTH-1:0] fetch_pc_q,  fetch_pc_d;
   logic [CPU_WIDTH-1:0] out_pc_q,    out_pc_d;
   logic [31:0]          out_inst_q,  out_inst_d;
   logic                 out_valid_q, out_valid_d;
   logic                 kill_q,      kill_d;
   logic [31:0]          fetch_cnt_q, fetch_cnt_d;

   logic [CPU_WIDTH-1:0] redirect_target;
   logic                 req_fire;

   // Redirect targets are always forced word aligned.
   assign redirect_target = {i_redirect_pc[CPU_WIDTH-1:2], 2'b00};
   assign req_fire        = (state_q == ST_REQ) && i_imem_req_ready;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      out_pc_d    = out_pc_q;
      out_inst_d  = out_inst_q;
      out_valid_d = out_valid_q;
      kill_d      = kill_q;
      fetch_cnt_d = fetch_cnt_q;

      case (state_q)
         ST_IDLE: begin
            // Redirects are not honoured until the first request is up.
            state_d = ST_REQ;
         end

         ST_REQ: begin
            if (i_redirect_valid) begin
               fetch_pc_d = redirect_target;
               // If imem took the old address this same cycle, its response
               // is stale and must be dropped when it returns.
               if (req_fire) begin
                  state_d = ST_WAIT;
                  kill_d  = 1'b1;
               end
            end else if (req_fire) begin
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (i_redirect_valid) begin
               fetch_pc_d = redirect_target;
               if (i_imem_rsp_valid) begin
                  // Response lands with the redirect: drop it right here,
                  // nothing remains outstanding so no kill is needed.
                  state_d = ST_REQ;
                  kill_d  = 1'b0;
               end else begin
                  kill_d  = 1'b1;
               end
            end else if (i_imem_rsp_valid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  out_pc_d    = fetch_pc_q;
                  out_inst_d  = i_imem_rsp_data;
                  out_valid_d = 1'b1;
                  fetch_pc_d  = fetch_pc_q + CPU_WIDTH'(4);
                  state_d     = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            // Redirect wins over a same-cycle consume: the held instruction
            // is on the wrong path and must not be counted.
            if (i_redirect_valid) begin
               fetch_pc_d  = redirect_target;
               out_valid_d = 1'b0;
               out_inst_d  = NOP_INST;
               state_d     = ST_REQ;
            end else if (out_valid_q && i_ifu_ready) begin
               out_valid_d = 1'b0;
               out_inst_d  = NOP_INST;
               fetch_cnt_d = fetch_cnt_q + 32'd1;
               state_d     = ST_REQ;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         fetch_pc_q  <= RESET_PC;
         out_pc_q    <= RESET_PC;
         out_inst_q  <= NOP_INST;
         out_valid_q <= 1'b0;
         kill_q      <= 1'b0;
         fetch_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         out_pc_q    <= out_pc_d;
         out_inst_q  <= out_inst_d;
         out_valid_q <= out_valid_d;
         kill_q      <= kill_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign o_imem_req_valid = (state_q == ST_REQ);
   assign o_imem_addr      = fetch_pc_q;
   assign o_ifu_valid      = out_valid_q;
   assign o_ifu_pc         = out_pc_q;
   assign o_ifu_inst       = out_inst_q;
   assign o_ifu_fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_ifu.sv
// ---------------------------------------------------------------------------
// tb_ifu -- directed self-checking bench for the instruction fetch unit.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        o_imem_req_valid;
   logic        i_imem_req_ready;
   logic [31:0] o_imem_addr;
   logic        i_imem_rsp_valid;
   logic [31:0] i_imem_rsp_data;
   logic        o_ifu_valid;
   logic        i_ifu_ready;
   logic [31:0] o_ifu_pc;
   logic [31:0] o_ifu_inst;
   logic        i_redirect_valid;
   logic [31:0] i_redirect_pc;
   logic [31:0] o_ifu_fetch_cnt;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   ifu dut (
      .clk              (clk),
      .rst              (rst),
      .o_imem_req_valid (o_imem_req_valid),
      .i_imem_req_ready (i_imem_req_ready),
      .o_imem_addr      (o_imem_addr),
      .i_imem_rsp_valid (i_imem_rsp_valid),
      .i_imem_rsp_data  (i_imem_rsp_data),
      .o_ifu_valid      (o_ifu_valid),
      .i_ifu_ready      (i_ifu_ready),
      .o_ifu_pc         (o_ifu_pc),
      .o_ifu_inst       (o_ifu_inst),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .o_ifu_fetch_cnt  (o_ifu_fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for a request, accepts it, returns the word one cycle
   // later. Leaves the DUT one cycle after the response edge (HOLD).
   task automatic fetch_one(input logic [31:0] data, output logic [31:0] addr);
      int n = 0;
      while (!o_imem_req_valid && n < 20) begin
         step();
         n++;
      end
      chk_cnt++;
      if (!o_imem_req_valid)
         $display("FAIL fetch_req_timeout: req_valid=%0b required 1", o_imem_req_valid);
      else
         pass_cnt++;
      addr = o_imem_addr;
      i_imem_req_ready = 1'b1;
      step();
      i_imem_req_ready = 1'b0;
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = data;
      step();
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      chk_cnt++;
      if (o_ifu_valid !== 1'b0 || o_ifu_inst !== NOP || o_ifu_pc !== RST_PC ||
          o_ifu_fetch_cnt !== 32'd0 || o_imem_req_valid !== 1'b0 || o_imem_addr !== RST_PC)
         $display("FAIL reset_values: valid=%0b inst=%h pc=%h cnt=%0d req=%0b addr=%h required 0/%h/%h/0/0/%h",
                  o_ifu_valid, o_ifu_inst, o_ifu_pc, o_ifu_fetch_cnt, o_imem_req_valid, o_imem_addr,
                  NOP, RST_PC, RST_PC);
      else
         pass_cnt++;
      step();
      rst = 1'b1;
      chk_cnt++;
      if (o_imem_req_valid !== 1'b0)
         $display("FAIL reset_idle: req_valid=%0b required 0", o_imem_req_valid);
      else
         pass_cnt++;
      step();
      chk_cnt++;
      if (o_imem_req_valid !== 1'b1 || o_imem_addr !== RST_PC)
         $display("FAIL reset_first_req: req=%0b addr=%h required 1/%h", o_imem_req_valid, o_imem_addr, RST_PC);
      else
         pass_cnt++;
      $display("reset: req=%0b addr=%h", o_imem_req_valid, o_imem_addr);
   endtask

   task automatic test_basic();
      logic [31:0] a;
      i_ifu_ready = 1'b1;
      fetch_one(32'h0010_0093, a);
      chk_cnt++;
      if (a !== 32'h8000_0000 || o_ifu_valid !== 1'b1 || o_ifu_pc !== 32'h8000_0000 || o_ifu_inst !== 32'h0010_0093)
         $display("FAIL basic_first: addr=%h valid=%0b pc=%h inst=%h required 80000000/1/80000000/00100093",
                  a, o_ifu_valid, o_ifu_pc, o_ifu_inst);
      else
         pass_cnt++;
      $display("basic: addr=%h pc=%h inst=%h", a, o_ifu_pc, o_ifu_inst);
      step();
      chk_cnt++;
      if (o_ifu_valid !== 1'b0 || o_ifu_fetch_cnt !== 32'd1 || o_imem_req_valid !== 1'b1 || o_imem_addr !== 32'h8000_0004)
         $display("FAIL basic_consume: valid=%0b cnt=%0d req=%0b addr=%h required 0/1/1/80000004",
                  o_ifu_valid, o_ifu_fetch_cnt, o_imem_req_valid, o_imem_addr);
      else
         pass_cnt++;
      fetch_one(32'h0020_0113, a);
      chk_cnt++;
      if (a !== 32'h8000_0004 || o_ifu_valid !== 1'b1 || o_ifu_pc !== 32'h8000_0004 || o_ifu_inst !== 32'h0020_0113)
         $display("FAIL basic_second: addr=%h valid=%0b pc=%h inst=%h required 80000004/1/80000004/00200113",
                  a, o_ifu_valid, o_ifu_pc, o_ifu_inst);
      else
         pass_cnt++;
      $display("basic: addr=%h pc=%h inst=%h", a, o_ifu_pc, o_ifu_inst);
      step();
      chk_cnt++;
      if (o_ifu_fetch_cnt !== 32'd2)
         $display("FAIL basic_count: cnt=%0d required 2", o_ifu_fetch_cnt);
      else
         pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [31:0] a;
      int bad = 0;
      i_ifu_ready = 1'b0;
      fetch_one(32'h0030_0193, a);
      for (int i = 0; i < 5; i++) begin
         if (o_ifu_valid !== 1'b1 || o_ifu_pc !== 32'h8000_0008 || o_ifu_inst !== 32'h0030_0193 ||
             o_imem_req_valid !== 1'b0 || o_ifu_fetch_cnt !== 32'd2)
            bad++;
         step();
      end
      chk_cnt++;
      if (bad != 0)
         $display("FAIL bp_stable: unstable cycles=%0d required 0 (last valid=%0b pc=%h inst=%h req=%0b)",
                  bad, o_ifu_valid, o_ifu_pc, o_ifu_inst, o_imem_req_valid);
      else
         pass_cnt++;
      i_ifu_ready = 1'b1;
      step();
      chk_cnt++;
      if (o_ifu_fetch_cnt !== 32'd3 || o_ifu_valid !== 1'b0)
         $display("FAIL bp_release: cnt=%0d valid=%0b required 3/0", o_ifu_fetch_cnt, o_ifu_valid);
      else
         pass_cnt++;
      step();
      chk_cnt++;
      if (o_ifu_fetch_cnt !== 32'd3 || o_imem_addr !== 32'h8000_000C)
         $display("FAIL bp_once: cnt=%0d addr=%h required 3/8000000c", o_ifu_fetch_cnt, o_imem_addr);
      else
         pass_cnt++;
      $display("backpressure: cnt=%0d next_addr=%h", o_ifu_fetch_cnt, o_imem_addr);
   endtask

   task automatic test_redirect_wait();
      logic [31:0] a;
      i_imem_req_ready = 1'b1;
      step();
      i_imem_req_ready = 1'b0;
      i_redirect_valid = 1'b1;
      i_redirect_pc    = 32'h8000_0102;
      step();
      i_redirect_valid = 1'b0;
      chk_cnt++;
      if (o_imem_addr !== 32'h8000_0100 || o_imem_req_valid !== 1'b0)
         $display("FAIL rw_wait: addr=%h req=%0b required 80000100/0", o_imem_addr, o_imem_req_valid);
      else
         pass_cnt++;
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = 32'hDEAD_BEEF;
      step();
      i_imem_rsp_valid = 1'b0;
      chk_cnt++;
      if (o_ifu_valid !== 1'b0 || o_imem_req_valid !== 1'b1 || o_imem_addr !== 32'h8000_0100)
         $display("FAIL rw_drop: valid=%0b req=%0b addr=%h required 0/1/80000100", o_ifu_valid, o_imem_req_valid, o_imem_addr);
      else
         pass_cnt++;
      fetch_one(32'h0040_0213, a);
      chk_cnt++;
      if (a !== 32'h8000_0100 || o_ifu_pc !== 32'h8000_0100 || o_ifu_inst !== 32'h0040_0213 || o_ifu_valid !== 1'b1)
         $display("FAIL rw_deliver: addr=%h pc=%h inst=%h valid=%0b required 80000100/80000100/00400213/1",
                  a, o_ifu_pc, o_ifu_inst, o_ifu_valid);
      else
         pass_cnt++;
      $display("redirect_wait: addr=%h pc=%h inst=%h", a, o_ifu_pc, o_ifu_inst);
      step();
      chk_cnt++;
      if (o_ifu_fetch_cnt !== 32'd4)
         $display("FAIL rw_count: cnt=%0d required 4", o_ifu_fetch_cnt);
      else
         pass_cnt++;
   endtask

   task automatic test_redirect_hold();
      logic [31:0] a;
      i_ifu_ready = 1'b0;
      fetch_one(32'h0050_0293, a);
      i_ifu_ready      = 1'b1;
      i_redirect_valid = 1'b1;
      i_redirect_pc    = 32'h8000_0200;
      step();
      i_redirect_valid = 1'b0;
      chk_cnt++;
      if (o_ifu_valid !== 1'b0 || o_ifu_inst !== NOP || o_ifu_fetch_cnt !== 32'd4 ||
          o_imem_req_valid !== 1'b1 || o_imem_addr !== 32'h8000_0200)
         $display("FAIL rh_flush: valid=%0b inst=%h cnt=%0d req=%0b addr=%h required 0/00000013/4/1/80000200",
                  o_ifu_valid, o_ifu_inst, o_ifu_fetch_cnt, o_imem_req_valid, o_imem_addr);
      else
         pass_cnt++;
      fetch_one(32'h0060_0313, a);
      chk_cnt++;
      if (a !== 32'h8000_0200 || o_ifu_pc !== 32'h8000_0200)
         $display("FAIL rh_target: addr=%h pc=%h required 80000200/80000200", a, o_ifu_pc);
      else
         pass_cnt++;
      $display("redirect_hold: addr=%h pc=%h cnt=%0d", a, o_ifu_pc, o_ifu_fetch_cnt);
      step();
   endtask

   task automatic test_redirect_req_accept();
      i_imem_req_ready = 1'b1;
      i_redirect_valid = 1'b1;
      i_redirect_pc    = 32'h8000_0301;
      step();
      i_imem_req_ready = 1'b0;
      i_redirect_valid = 1'b0;
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = 32'hBAD0_BAD0;
      step();
      i_imem_rsp_valid = 1'b0;
      chk_cnt++;
      if (o_ifu_valid !== 1'b0 || o_imem_req_valid !== 1'b1 || o_imem_addr !== 32'h8000_0300 || o_ifu_fetch_cnt !== 32'd5)
         $display("FAIL rq_kill: valid=%0b req=%0b addr=%h cnt=%0d required 0/1/80000300/5",
                  o_ifu_valid, o_imem_req_valid, o_imem_addr, o_ifu_fetch_cnt);
      else
         pass_cnt++;
      $display("redirect_req_accept: addr=%h valid=%0b", o_imem_addr, o_ifu_valid);
   endtask

   task automatic test_wrap();
      logic [31:0] a;
      i_redirect_valid = 1'b1;
      i_redirect_pc    = 32'hFFFF_FFFC;
      step();
      i_redirect_valid = 1'b0;
      chk_cnt++;
      if (o_imem_addr !== 32'hFFFF_FFFC || o_imem_req_valid !== 1'b1)
         $display("FAIL wrap_redirect: addr=%h req=%0b required fffffffc/1", o_imem_addr, o_imem_req_valid);
      else
         pass_cnt++;
      fetch_one(32'h0070_0393, a);
      chk_cnt++;
      if (a !== 32'hFFFF_FFFC || o_ifu_pc !== 32'hFFFF_FFFC)
         $display("FAIL wrap_first: addr=%h pc=%h required fffffffc/fffffffc", a, o_ifu_pc);
      else
         pass_cnt++;
      step();
      fetch_one(32'h0080_0413, a);
      chk_cnt++;
      if (a !== 32'h0000_0000 || o_ifu_pc !== 32'h0000_0000 || o_ifu_inst !== 32'h0080_0413)
         $display("FAIL wrap_second: addr=%h pc=%h inst=%h required 00000000/00000000/00800413", a, o_ifu_pc, o_ifu_inst);
      else
         pass_cnt++;
      $display("wrap: addr=%h pc=%h", a, o_ifu_pc);
      step();
      chk_cnt++;
      if (o_ifu_fetch_cnt !== 32'd7)
         $display("FAIL wrap_count: cnt=%0d required 7", o_ifu_fetch_cnt);
      else
         pass_cnt++;
   endtask

   task automatic test_reset_in_wait();
      i_imem_req_ready = 1'b1;
      step();
      i_imem_req_ready = 1'b0;
      rst = 1'b0;
      #1;
      chk_cnt++;
      if (o_ifu_valid !== 1'b0 || o_ifu_inst !== NOP || o_ifu_fetch_cnt !== 32'd0 ||
          o_imem_req_valid !== 1'b0 || o_imem_addr !== RST_PC || o_ifu_pc !== RST_PC)
         $display("FAIL rstw_values: valid=%0b inst=%h cnt=%0d req=%0b addr=%h pc=%h required 0/00000013/0/0/%h/%h",
                  o_ifu_valid, o_ifu_inst, o_ifu_fetch_cnt, o_imem_req_valid, o_imem_addr, o_ifu_pc, RST_PC, RST_PC);
      else
         pass_cnt++;
      step();
      step();
      step();
      rst = 1'b1;
      chk_cnt++;
      if (o_imem_req_valid !== 1'b0)
         $display("FAIL rstw_idle: req=%0b required 0", o_imem_req_valid);
      else
         pass_cnt++;
      step();
      chk_cnt++;
      if (o_imem_req_valid !== 1'b1 || o_imem_addr !== RST_PC)
         $display("FAIL rstw_first_req: req=%0b addr=%h required 1/%h", o_imem_req_valid, o_imem_addr, RST_PC);
      else
         pass_cnt++;
      $display("reset_in_wait: req=%0b addr=%h cnt=%0d", o_imem_req_valid, o_imem_addr, o_ifu_fetch_cnt);
   endtask

   initial begin
      rst              = 1'b0;
      i_imem_req_ready = 1'b0;
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = 32'h0;
      i_ifu_ready      = 1'b0;
      i_redirect_valid = 1'b0;
      i_redirect_pc    = 32'h0;
      test_reset();
      test_basic();
      test_backpressure();
      test_redirect_wait();
      test_redirect_hold();
      test_redirect_req_accept();
      test_wrap();
      test_reset_in_wait();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
